// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one external full adder LSB first,
// one bit per clock, with valid/ready request and response handshakes.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   start_valid/start_ready   request handshake; op_a, op_b, cin operands
//   fa_a, fa_b, fa_cin        to the external full adder
//   fa_sum, fa_cout           from the external full adder
//   result, cout              collected sum bits and final carry
//   done_valid/done_ready     response handshake
//   busy                      high whenever the controller is not idle
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             done_valid,
   input  logic             done_ready,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             run;

   assign run = (state == RUN);

   // Adder inputs come only from registers; gated to 0 outside RUN
   // because the carry register still holds the final carry in DONE.
   assign fa_a   = run & a_sh[0];
   assign fa_b   = run & b_sh[0];
   assign fa_cin = run & carry;

   // Low while reset is held, even though state is already IDLE.
   assign start_ready = (state == IDLE) & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         result     <= '0;
         cout       <= 1'b0;
         done_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_valid) begin
                  a_sh  <= op_a;
                  b_sh  <= op_b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // Sum bits enter at the top and walk down to bit 0.
               result <= {fa_sum, result[WIDTH-1:1]};
               carry  <= fa_cout;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  cout       <= fa_cout;
                  done_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (done_ready) begin
                  done_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl with a behavioural full adder.
// Ports: none (top-level bench).
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             done_valid;
   logic             done_ready;
   logic             busy;

   int total;
   int passed;
   int fails;
   int n;
   int last_acc;
   int idx_in;
   int idx_out;
   logic       seen;
   logic [7:0] seq;
   logic [7:0] ta [3];
   logic [7:0] tb [3];
   logic       tc [3];
   logic [8:0] tsum;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .cin         (cin),
      .fa_a        (fa_a),
      .fa_b        (fa_b),
      .fa_cin      (fa_cin),
      .fa_sum      (fa_sum),
      .fa_cout     (fa_cout),
      .result      (result),
      .cout        (cout),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .busy        (busy)
   );

   // External full adder.
   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic ci,
                         output logic [7:0] fseq);
      logic [8:0] s;
      int lat;
      logic got;
      s = 9'(a) + 9'(b) + 9'(ci);
      fseq = '0;
      @(negedge clk);
      op_a = a;
      op_b = b;
      cin = ci;
      start_valid = 1'b1;
      done_ready = 1'b1;
      #1;
      chk({tag, "_ready"}, 32'(start_ready), 32'd1);
      @(posedge clk);
      #1 start_valid = 1'b0;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (done_valid) got = 1'b1;
         else if (lat <= 8) fseq = {fa_a, fseq[7:1]};
      end
      chk({tag, "_lat"}, 32'(lat), 32'd9);
      chk({tag, "_res"}, 32'(result), 32'(s[7:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(s[8]));
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      passed = 0;
      fails = 0;
      rst = 1'b1;
      start_valid = 1'b0;
      op_a = '0;
      op_b = '0;
      cin = 1'b0;
      done_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(start_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done_valid), 32'd0);
      chk("rst_res", 32'(result), 32'd0);
      chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_ready", 32'(start_ready), 32'd1);

      // Basic additions
      run_op("t5a3c", 8'h5A, 8'h3C, 1'b0, seq);
      chk("t5a3c_fa_a_seq", 32'(seq), 32'h5A);
      run_op("tff01", 8'hFF, 8'h01, 1'b0, seq);
      run_op("tffff1", 8'hFF, 8'hFF, 1'b1, seq);
      run_op("t00001", 8'h00, 8'h00, 1'b1, seq);
      run_op("t8080", 8'h80, 8'h80, 1'b0, seq);

      // Backpressure in DONE
      @(negedge clk);
      op_a = 8'h12;
      op_b = 8'h34;
      cin = 1'b0;
      start_valid = 1'b1;
      done_ready = 1'b0;
      @(posedge clk);
      #1 start_valid = 1'b0;
      n = 0;
      while (!done_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_reach", 32'(done_valid), 32'd1);
      chk("bp_res0", 32'(result), 32'h46);
      for (int i = 0; i < 5; i++) begin
         start_valid = ~start_valid;
         op_a = op_a + 8'h11;
         @(negedge clk);
         chk("bp_res", 32'(result), 32'h46);
         chk("bp_cout", 32'(cout), 32'd0);
         chk("bp_sready", 32'(start_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
         chk("bp_dvalid", 32'(done_valid), 32'd1);
      end
      start_valid = 1'b1;
      op_a = 8'h10;
      op_b = 8'h20;
      cin = 1'b0;
      done_ready = 1'b1;
      @(negedge clk);
      chk("bp_idle_busy", 32'(busy), 32'd0);
      chk("bp_idle_sready", 32'(start_ready), 32'd1);
      chk("bp_idle_dvalid", 32'(done_valid), 32'd0);
      @(posedge clk);
      #1 start_valid = 1'b0;
      n = 0;
      while (!done_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_next_lat", 32'(n), 32'd9);
      chk("bp_next_res", 32'(result), 32'h30);
      @(posedge clk);
      #1;

      // Reset mid-RUN
      @(negedge clk);
      op_a = 8'h5A;
      op_b = 8'h3C;
      cin = 1'b0;
      start_valid = 1'b1;
      @(posedge clk);
      #1 start_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_dvalid", 32'(done_valid), 32'd0);
      chk("abort_sready", 32'(start_ready), 32'd0);
      chk("abort_res", 32'(result), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_valid) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      chk("abort_sready_back", 32'(start_ready), 32'd1);
      run_op("t0102", 8'h01, 8'h02, 1'b0, seq);

      // Back-to-back with start_valid and done_ready held high
      ta[0] = 8'h11; tb[0] = 8'h22; tc[0] = 1'b0;
      ta[1] = 8'hF0; tb[1] = 8'h0F; tc[1] = 1'b1;
      ta[2] = 8'hC3; tb[2] = 8'h7E; tc[2] = 1'b1;
      idx_in = 0;
      idx_out = 0;
      last_acc = 0;
      @(negedge clk);
      op_a = ta[0];
      op_b = tb[0];
      cin = tc[0];
      start_valid = 1'b1;
      done_ready = 1'b1;
      for (int c = 0; c < 60 && idx_out < 3; c++) begin
         seen = 1'b0;
         if (start_valid && start_ready) begin
            if (idx_in > 0) chk("b2b_gap", 32'(c - last_acc), 32'd10);
            last_acc = c;
            idx_in++;
            seen = 1'b1;
         end
         if (done_valid) begin
            tsum = 9'(ta[idx_out]) + 9'(tb[idx_out]) + 9'(tc[idx_out]);
            chk("b2b_res", 32'(result), 32'(tsum[7:0]));
            chk("b2b_cout", 32'(cout), 32'(tsum[8]));
            idx_out++;
         end
         @(posedge clk);
         #1;
         if (seen) begin
            if (idx_in < 3) begin
               op_a = ta[idx_in];
               op_b = tb[idx_in];
               cin = tc[idx_in];
            end else begin
               start_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      chk("b2b_count", 32'(idx_out), 32'd3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
